// File: rtl/mips_single_cycle_top.sv
// Single-cycle MIPS subset (add/sub/and/or/slt/lw/sw/beq/addi/j) with a fixed
// 64-word program ROM and a 64-word data RAM; the data bus is exposed as ports.
module mips_single_cycle_top (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] write_data,
    output logic [31:0] data_addr,
    output logic        mem_write,
    output logic        mem_read
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    // Self-check program; final store writes 7 to byte address 84.
    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        logic [31:0] w;
        case (idx)
            6'd0:    w = 32'h20020005;
            6'd1:    w = 32'h2003000c;
            6'd2:    w = 32'h2067fff7;
            6'd3:    w = 32'h00e22025;
            6'd4:    w = 32'h00642824;
            6'd5:    w = 32'h00a42820;
            6'd6:    w = 32'h10a7000a;
            6'd7:    w = 32'h0064202a;
            6'd8:    w = 32'h10800001;
            6'd9:    w = 32'h20050000;
            6'd10:   w = 32'h00e2202a;
            6'd11:   w = 32'h00853820;
            6'd12:   w = 32'h00e23822;
            6'd13:   w = 32'hac670044;
            6'd14:   w = 32'h8c020050;
            6'd15:   w = 32'h08000011;
            6'd16:   w = 32'h20020001;
            6'd17:   w = 32'hac020054;
            default: w = 32'h00000000;
        endcase
        return w;
    endfunction

    logic [31:0] pc_r;
    logic [31:0] regs_r [32];
    logic [31:0] ram_r  [64];

    logic [31:0] instr_s;
    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_ext_s;
    logic [31:0] rs_val_s;
    logic [31:0] rt_val_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_y_s;
    logic [31:0] ram_rd_s;
    logic [31:0] wb_s;
    logic [4:0]  wr_addr_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;

    logic        reg_write_s;
    logic        reg_dst_s;
    logic        alu_src_s;
    logic        mem_to_reg_s;
    logic        mem_write_s;
    logic        mem_read_s;
    logic        branch_s;
    logic        jump_s;
    alu_op_t     alu_op_s;

    assign instr_s   = rom_word(pc_r[7:2]);
    assign op_s      = instr_s[31:26];
    assign rs_s      = instr_s[25:21];
    assign rt_s      = instr_s[20:16];
    assign rd_s      = instr_s[15:11];
    assign funct_s   = instr_s[5:0];
    assign imm_ext_s = {{16{instr_s[15]}}, instr_s[15:0]};

    assign rs_val_s  = (rs_s == 5'd0) ? 32'd0 : regs_r[rs_s];
    assign rt_val_s  = (rt_s == 5'd0) ? 32'd0 : regs_r[rt_s];

    // Main decoder: anything unrecognised leaves all write enables low.
    always_comb begin
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        alu_src_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        mem_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        branch_s     = 1'b0;
        jump_s       = 1'b0;
        alu_op_s     = ALU_ADD;
        case (op_s)
            6'h00: begin
                reg_dst_s = 1'b1;
                case (funct_s)
                    6'h20: begin reg_write_s = 1'b1; alu_op_s = ALU_ADD; end
                    6'h22: begin reg_write_s = 1'b1; alu_op_s = ALU_SUB; end
                    6'h24: begin reg_write_s = 1'b1; alu_op_s = ALU_AND; end
                    6'h25: begin reg_write_s = 1'b1; alu_op_s = ALU_OR;  end
                    6'h2A: begin reg_write_s = 1'b1; alu_op_s = ALU_SLT; end
                    default: reg_write_s = 1'b0;
                endcase
            end
            6'h23: begin
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                mem_to_reg_s = 1'b1;
                mem_read_s   = 1'b1;
            end
            6'h2B: begin
                alu_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            6'h04: begin
                branch_s = 1'b1;
                alu_op_s = ALU_SUB;
            end
            6'h08: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
            end
            6'h02: jump_s = 1'b1;
            default: jump_s = 1'b0;
        endcase
    end

    assign alu_b_s = alu_src_s ? imm_ext_s : rt_val_s;

    // ALU; overflow is deliberately ignored.
    always_comb begin
        alu_y_s = 32'd0;
        case (alu_op_s)
            ALU_ADD: alu_y_s = rs_val_s + alu_b_s;
            ALU_SUB: alu_y_s = rs_val_s - alu_b_s;
            ALU_AND: alu_y_s = rs_val_s & alu_b_s;
            ALU_OR:  alu_y_s = rs_val_s | alu_b_s;
            ALU_SLT: alu_y_s = ($signed(rs_val_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
            default: alu_y_s = 32'd0;
        endcase
    end

    assign ram_rd_s  = ram_r[alu_y_s[7:2]];
    assign wb_s      = mem_to_reg_s ? ram_rd_s : alu_y_s;
    assign wr_addr_s = reg_dst_s ? rd_s : rt_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // Next-PC select: taken beq, then j, otherwise sequential.
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (branch_s && (rs_val_s == rt_val_s)) begin
            pc_next_s = pc_plus4_s + {imm_ext_s[29:0], 2'b00};
        end else if (jump_s) begin
            pc_next_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Program counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= 32'd0;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Register file write port; $0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (reg_write_s && (wr_addr_s != 5'd0)) begin
            regs_r[wr_addr_s] <= wb_s;
        end
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_write_s) begin
            ram_r[alu_y_s[7:2]] <= rt_val_s;
        end
    end

    assign write_data = rt_val_s;
    assign data_addr  = alu_y_s;
    assign mem_write  = mem_write_s;
    assign mem_read   = mem_read_s;

endmodule

// File: tb/tb_mips_single_cycle_top.sv
// Directed bench: walks the executed-instruction trace of the built-in program
// and checks the data bus each cycle, across several resets.
module tb_mips_single_cycle_top;

    logic        clk;
    logic        reset;
    logic [31:0] write_data;
    logic [31:0] data_addr;
    logic        mem_write;
    logic        mem_read;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          word;
        logic        chk_addr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mw;
        logic        mr;
    } vec_t;

    vec_t vecs [16];

    mips_single_cycle_top dut (
        .clk        (clk),
        .reset      (reset),
        .write_data (write_data),
        .data_addr  (data_addr),
        .mem_write  (mem_write),
        .mem_read   (mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, data_addr, 32'd5);
        check({tag, "_mw"}, {31'd0, mem_write}, 32'd0);
        check({tag, "_mr"}, {31'd0, mem_read}, 32'd0);
    endtask

    // Expects to be entered just after a falling edge with word 0 presented.
    task automatic run_program(input int n, input int pass);
        string nm;
        for (int i = 0; i < n; i++) begin
            nm = $sformatf("p%0d_w%0d", pass, vecs[i].word);
            if (vecs[i].chk_addr) check({nm, "_addr"}, data_addr, vecs[i].addr);
            check({nm, "_wdata"}, write_data, vecs[i].wdata);
            check({nm, "_mw"}, {31'd0, mem_write}, {31'd0, vecs[i].mw});
            check({nm, "_mr"}, {31'd0, mem_read}, {31'd0, vecs[i].mr});
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_nops(input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("nop%0d_mw", i), {31'd0, mem_write}, 32'd0);
            check($sformatf("nop%0d_mr", i), {31'd0, mem_read}, 32'd0);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        //                word chk  addr    wdata   mw    mr
        vecs[0]  = '{0,  1'b1, 32'd5,  32'd0,  1'b0, 1'b0};
        vecs[1]  = '{1,  1'b1, 32'd12, 32'd0,  1'b0, 1'b0};
        vecs[2]  = '{2,  1'b1, 32'd3,  32'd0,  1'b0, 1'b0};
        vecs[3]  = '{3,  1'b1, 32'd7,  32'd5,  1'b0, 1'b0};
        vecs[4]  = '{4,  1'b1, 32'd4,  32'd7,  1'b0, 1'b0};
        vecs[5]  = '{5,  1'b1, 32'd11, 32'd7,  1'b0, 1'b0};
        vecs[6]  = '{6,  1'b1, 32'd8,  32'd3,  1'b0, 1'b0};
        vecs[7]  = '{7,  1'b1, 32'd0,  32'd7,  1'b0, 1'b0};
        vecs[8]  = '{8,  1'b1, 32'd0,  32'd0,  1'b0, 1'b0};
        vecs[9]  = '{10, 1'b1, 32'd1,  32'd5,  1'b0, 1'b0};
        vecs[10] = '{11, 1'b1, 32'd12, 32'd11, 1'b0, 1'b0};
        vecs[11] = '{12, 1'b1, 32'd7,  32'd5,  1'b0, 1'b0};
        vecs[12] = '{13, 1'b1, 32'd80, 32'd7,  1'b1, 1'b0};
        vecs[13] = '{14, 1'b1, 32'd80, 32'd5,  1'b0, 1'b1};
        vecs[14] = '{15, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0};
        vecs[15] = '{17, 1'b1, 32'd84, 32'd7,  1'b1, 1'b0};

        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst0");
        check("rst0_wdata", write_data, 32'd0);
        reset = 1'b1;
        run_program(16, 1);
        run_nops(10);

        // One-cycle reset after the final store, then a full rerun.
        reset = 1'b0;
        #1;
        check_reset_state("rst1");
        @(negedge clk);
        #1;
        check_reset_state("rst1_hold");
        reset = 1'b1;
        run_program(16, 2);
        run_nops(4);

        // Reset again, run partway, then hit reset asynchronously mid-program.
        reset = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        run_program(7, 3);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("rst_async");
        @(negedge clk);
        #1;
        reset = 1'b1;
        run_program(16, 4);
        run_nops(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
